// File: rtl/xenyx_pkg.sv
// Shared definitions for the Xenyx-4 core: datapath defaults, the fetch state
// encoding and the RV32 opcode map used by fetch, decode and immediate generation.
package xenyx_pkg;

    localparam int unsigned      XLEN_DEFAULT     = 32;
    localparam logic [31:0]      RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

    // Major opcodes (instr[6:0]) shared with decode and the immediate generator.
    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the pc, keeps one instruction-memory read in flight at most,
// hands {instr, pc} to decode and squashes wrong-path fetches on redirect.
module instruction_fetch
    import xenyx_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_instr_q, if_instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;

    // Reset parks the FSM in S_REQ, so the request is gated by rst_n itself.
    assign imem_req_valid = rst_n && (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign if_valid       = if_valid_q;
    assign if_instr       = if_instr_q;
    assign if_pc          = if_pc_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;

        if (redirect_valid) begin
            pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
            if_valid_d = 1'b0;
            unique case (state_q)
                S_REQ:   state_d = imem_req_ready ? S_DROP : S_REQ;
                S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
                S_OUT:   state_d = S_REQ;
                S_DROP:  state_d = S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem_req_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if_instr_d = imem_rsp_data;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + XLEN'(4);
                        state_d    = S_OUT;
                    end
                end
                S_OUT: begin
                    if (if_ready) begin
                        if_valid_d = 1'b0;
                        state_d    = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            // NOTE: non-blocking updates so all state moves together on the edge.
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

endmodule
